// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and width defaults for the memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 16;
    typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks the winning port; MEM_ARB_ROUND_ROBIN_EN adds a last_grant register for alternation.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant,
`endif
    input  logic [1:0] req,
    output port_t      winner
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_t last_grant;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= PORT_I;
        else if (grant) last_grant <= winner;
    end
    // Contention goes to whichever port did not win last time.
    always_comb winner = &req ? (last_grant == PORT_D ? PORT_I : PORT_D)
                              : (req[PORT_D] ? PORT_D : PORT_I);
`else
    always_comb winner = req[PORT_D] ? PORT_D : PORT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters; MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);
    arb_state_t state, state_nxt;
    port_t      winner;
    logic [1:0] req;
    logic       load, done, win_wr;
    assign req = {d_read | d_write, i_read};
    mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .rst_n  (rst_n),
        .grant  (load),
`endif
        .req    (req),
        .winner (winner)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        load      = state == ARB_IDLE && |req;
        done      = state != ARB_IDLE && mem_resp;
        i_resp    = state == ARB_SERVE_I && mem_resp;
        d_resp    = state == ARB_SERVE_D && mem_resp;
        win_wr    = winner == PORT_D && d_write;
        state_nxt = state;
        if (load) state_nxt = winner == PORT_D ? ARB_SERVE_D : ARB_SERVE_I;
        else if (done) state_nxt = ARB_IDLE;
    end
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    // Memory sees only these captured values, so requester changes mid-transaction are invisible to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
        end else if (load) begin
            mem_read        <= !win_wr;
            mem_write       <= win_wr;
            mem_byte_enable <= win_wr ? d_byte_enable : '1;
            mem_address     <= winner == PORT_D ? d_address : i_address;
            mem_wdata       <= winner == PORT_D ? d_wdata : '0;
        end else if (done) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
    typedef struct {
        logic        port;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] rdata;
    } item_t;

    logic        clk = 0, rst_n = 0;
    logic        i_read = 0, i_resp;
    logic [15:0] i_address = 0, i_rdata;
    logic        d_read = 0, d_write = 0, d_resp;
    logic [1:0]  d_byte_enable = 0, mem_byte_enable;
    logic [15:0] d_address = 0, d_wdata = 0, d_rdata;
    logic        mem_read, mem_write, mem_resp = 0;
    logic [15:0] mem_address, mem_wdata, mem_rdata = 0;
    item_t       exp_q[$];
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic item_t mk(input logic port, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be, input logic [15:0] rdata);
        item_t e;
        e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be; e.rdata = rdata;
        return e;
    endfunction

    task automatic wait_strobe();
        int n = 0;
        item_t e;
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("grant_timeout", n < 20, 1);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("mem_address", mem_address, e.addr);
            chk("mem_write", mem_write, e.wr);
            chk("mem_read", mem_read, !e.wr);
            chk("mem_byte_enable", mem_byte_enable, e.be);
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
        end
    endtask

    task automatic respond(input int lat);
        item_t e;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int k = 0; k < lat; k++) begin
            @(negedge clk); #1;
            chk("hold_addr", mem_address, e.addr);
            chk("hold_strobe", e.wr ? mem_write : mem_read, 1);
            chk("early_resp", i_resp | d_resp, 0);
        end
        mem_resp = 1; mem_rdata = e.rdata;
        #1;
        chk("i_resp", i_resp, !e.port);
        chk("d_resp", d_resp, e.port);
        chk("rdata", e.port ? d_rdata : i_rdata, e.rdata);
        @(negedge clk);
        mem_resp = 0; mem_rdata = 0;
        if (e.port) begin d_read = 0; d_write = 0; end else i_read = 0;
        #1;
        chk("bubble_strobe", mem_read | mem_write, 0);
        chk("bubble_resp", i_resp | d_resp, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read", mem_read, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_be", mem_byte_enable, 0);
        chk("rst_resp", i_resp | d_resp, 0);
        @(negedge clk); rst_n = 1;

        // fetch alone
        @(negedge clk);
        i_read = 1; i_address = 16'h0040;
        exp_q.push_back(mk(0, 0, 16'h0040, 0, 2'b11, 16'h1234));
        #1 chk("fetch_no_early", mem_read, 0);
        @(negedge clk); #1;
        chk("fetch_latency", mem_read, 1);
        wait_strobe();
        respond(3);

        // data write alone
        @(negedge clk);
        d_write = 1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_byte_enable = 2'b10;
        exp_q.push_back(mk(1, 1, 16'h0100, 16'hBEEF, 2'b10, 16'h0000));
        wait_strobe();
        respond(2);

        // simultaneous reads
        @(negedge clk);
        i_read = 1; i_address = 16'h0040;
        d_read = 1; d_address = 16'h0200;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_q.push_back(mk(0, 0, 16'h0040, 0, 2'b11, 16'h6666));
        exp_q.push_back(mk(1, 0, 16'h0200, 0, 2'b11, 16'h5555));
`else
        exp_q.push_back(mk(1, 0, 16'h0200, 0, 2'b11, 16'h5555));
        exp_q.push_back(mk(0, 0, 16'h0040, 0, 2'b11, 16'h6666));
`endif
        wait_strobe();
        respond(1);
        wait_strobe();
        respond(2);

        // address change mid-transaction
        @(negedge clk);
        d_read = 1; d_address = 16'h0200;
        exp_q.push_back(mk(1, 0, 16'h0200, 0, 2'b11, 16'hA5A5));
        wait_strobe();
        @(negedge clk);
        d_address = 16'h0300;
        #1 chk("addr_held", mem_address, 16'h0200);
        respond(2);

        // read+write together acts as write
        @(negedge clk);
        d_read = 1; d_write = 1; d_address = 16'h0500; d_wdata = 16'h00FF; d_byte_enable = 2'b01;
        exp_q.push_back(mk(1, 1, 16'h0500, 16'h00FF, 2'b01, 16'h0000));
        wait_strobe();
        respond(1);

        // spurious mem_resp while idle
        @(negedge clk);
        mem_resp = 1; mem_rdata = 16'hDEAD;
        #1;
        chk("spurious_i_resp", i_resp, 0);
        chk("spurious_d_resp", d_resp, 0);
        @(negedge clk);
        mem_resp = 0;
        #1 chk("spurious_strobe", mem_read | mem_write, 0);

        // reset during SERVE_D
        @(negedge clk);
        d_write = 1; d_address = 16'h0400; d_wdata = 16'h1111; d_byte_enable = 2'b11;
        @(negedge clk); #1;
        chk("pre_rst_write", mem_write, 1);
        @(negedge clk);
        rst_n = 0;
        #1 chk("rst_drop_write", mem_write, 0);
        @(negedge clk);
        rst_n = 1; d_write = 0;
        @(negedge clk);
        mem_resp = 1;
        #1;
        chk("post_rst_d_resp", d_resp, 0);
        chk("post_rst_i_resp", i_resp, 0);
        @(negedge clk);
        mem_resp = 0;
        #1 chk("post_rst_idle", mem_read | mem_write, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit memory port (read/write/byte-enable/address/wdata, resp/rdata handshake) between an instruction-fetch requester (read-only) and a data requester (read/write).
- Sits between the CPU datapath and the memory model.
- Registers the winning request and presents it to memory until mem_resp.
- Routes the response back to the winner only.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  fetch read request, held until i_resp.
- i_address  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch read data, valid when i_resp=1.
- i_resp  out  1  fetch completion, one-cycle pulse.
- d_read  in  1  data read request, held until d_resp.
- d_write  in  1  data write request, held until d_resp.
- d_byte_enable  in  DATA_W/8  write byte mask.
- d_address  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data, valid when d_resp=1.
- d_resp  out  1  data completion, one-cycle pulse.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  DATA_W/8  memory write mask.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_resp  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: async on rst_n=0.
  - State goes to IDLE; last_grant=I.
  - All registered outputs clear to 0 immediately: mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata.
  - i_resp=d_resp=0.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - If any request is present, choose a winner (see priority).
  - Capture the winner's address, wdata, byte_enable and op into registers.
  - Go to SERVE_x next cycle. Memory strobes assert on the first cycle of SERVE_x, so grant latency is 1 cycle.
  - With no request, stay in IDLE.
- Priority (default build): data port wins over fetch when both are requesting in IDLE.
- SERVE_x:
  - Memory outputs driven only from the captured registers, so requester changes mid-transaction do not affect memory.
  - mem_read=1 for a read; mem_write=1 with the captured mask for a write.
  - mem_byte_enable=2'b11 for reads.
- On mem_resp=1 in SERVE_x:
  - x_resp=1 combinationally in the same cycle; x_rdata=mem_rdata.
  - The other port's resp stays 0.
  - Next state IDLE; strobes are 0 in that IDLE cycle. This gives a guaranteed one-cycle bubble between memory transactions.
- i_rdata/d_rdata: mem_rdata passed through. Value is meaningful only while the matching resp=1.
- d_read and d_write both 1: treated as a write; the read is dropped. No error flag.
- mem_resp in IDLE (spurious or late): ignored, no resp generated.
- Requester still asserting in the IDLE cycle after its resp: treated as a new request and arbitrated normally.
- rst_n asserted during SERVE_x: transaction aborted, strobes drop asynchronously, no resp issued. A mem_resp after reset release is ignored because the state is IDLE.
- Write ordering: a single outstanding transaction only; no reordering.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests in IDLE, grant the port that was NOT in last_grant.
  - last_grant updates on each grant.
  - Lone requests are granted regardless of last_grant.
  - Guarantees neither port waits more than one transaction.
- Undefined: fixed data-over-fetch priority. last_grant register is not built; fetch can starve under continuous data traffic.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
  - typedef enum port_t {PORT_I, PORT_D}.
  - Width constants ADDR_W/DATA_W defaults.
- Sub-module mem_arb_grant: takes request vector and last_grant, returns winner. Owns the last_grant register under the macro.
- FSM and capture registers live in mem_arbiter.

Test Plan:
- Fetch alone, i_address=16'h0040, memory returns 16'h1234 after 3 cycles:
  - mem_read rises 1 cycle after i_read.
  - mem_address=0040; i_resp=1 with i_rdata=1234 for exactly 1 cycle; d_resp stays 0.
- Data write alone, d_address=16'h0100, d_wdata=16'hBEEF, d_byte_enable=2'b10:
  - mem_write=1, mem_byte_enable=10, mem_wdata=BEEF until resp.
  - d_resp pulses once.
- Simultaneous i_read(0x0040) and d_read(0x0200), default build:
  - D served first, then one IDLE bubble, then I served.
  - With MEM_ARB_ROUND_ROBIN_EN and last_grant=D: I served first.
- Data requester changes d_address 0x0200→0x0300 mid-transaction:
  - mem_address holds 0x0200 until mem_resp.
- mem_resp pulsed while IDLE with no requests: no i_resp/d_resp.
- rst_n low for 1 cycle during SERVE_D:
  - mem_write drops in the same cycle; state IDLE.
  - A following mem_resp produces no d_resp.
